// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its decoder-facing word format.
package fetch_pkg;

    localparam int INST_W = 32;

    // All-zero word decodes as a no-write NOP; fetch treats it as end of program.
    localparam logic [INST_W-1:0] HALT_WORD = 32'h0;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_e;

    // Decoder field layout, MSB first.
    typedef struct packed {
        logic       mux_sel;     // [31]
        logic [5:0] rs;          // [30:25]
        logic [5:0] rd;          // [24:19]
        logic [3:0] alu_op_sel;  // [18:15]
        logic [5:0] rt;          // [14:9]
        logic [8:0] imm;         // [8:0]
    } inst_fields_t;

    function automatic logic is_halt_word(input logic [INST_W-1:0] word);
        return word == HALT_WORD;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: instruction memory read port plus the decoder valid/ready handshake.
interface inst_fetch_if #(
    parameter int PC_W = 8
) ();
    import fetch_pkg::*;

    logic              imem_rd_en;
    logic [PC_W-1:0]   imem_addr;
    logic [INST_W-1:0] imem_data;
    logic [INST_W-1:0] inst;
    logic [PC_W-1:0]   inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        output imem_rd_en,
        output imem_addr,
        input  imem_data,
        output inst,
        output inst_pc,
        output inst_valid,
        input  inst_ready
    );

    modport slave (
        input  imem_rd_en,
        input  imem_addr,
        output imem_data,
        input  inst,
        input  inst_pc,
        input  inst_valid,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry FIFO of {instruction, pc}; push and pop may coincide at any occupancy.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [INST_W-1:0] push_inst,
    input  logic [PC_W-1:0]   push_pc,
    input  logic              pop,
    output logic [1:0]        count,
    output logic [INST_W-1:0] head_inst,
    output logic [PC_W-1:0]   head_pc
);

    localparam int ENTRY_W = INST_W + PC_W;

    logic [ENTRY_W-1:0] entry_q [2];
    logic [1:0]         entry_we;
    logic               wr_ptr_q, wr_ptr_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [1:0]         count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + 2'(push) - 2'(pop);
    end

    // Payload storage needs no reset; the top gates the head with occupancy.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        assign entry_we[gi] = push && (wr_ptr_q == 1'(gi));

        always_ff @(posedge clk) begin
            if (entry_we[gi]) begin
                entry_q[gi] <= {push_inst, push_pc};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count     = count_q;
    assign head_inst = entry_q[rd_ptr_q][ENTRY_W-1:PC_W];
    assign head_pc   = entry_q[rd_ptr_q][PC_W-1:0];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory read issue, return capture into a 2-entry queue, HALT detection.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int PC_W     = 8,
    parameter int RESET_PC = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            halted,
    inst_fetch_if.master    bus
);

    localparam logic [PC_W-1:0] RESET_ADDR = PC_W'(RESET_PC);
    localparam logic [PC_W-1:0] LAST_ADDR  = '1;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            stop_q, stop_d;
    logic            inflight_q, inflight_d;
    logic [PC_W-1:0] inflight_pc_q, inflight_pc_d;

    logic              issue;
    logic              push;
    logic              pop;
    logic              valid;
    logic [1:0]        fifo_count;
    logic [INST_W-1:0] head_inst;
    logic [PC_W-1:0]   head_pc;

    assign valid = (fifo_count != 2'd0);
    assign pop   = valid && bus.inst_ready;

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        stop_d        = stop_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        issue         = 1'b0;
        push          = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = RESET_ADDR;
                    stop_d  = 1'b0;
                end
            end

            RUN: begin
                // Queued plus in-flight words never exceed the two queue slots.
                issue = !stop_q &&
                        (({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop}));
                if (issue) begin
                    inflight_d    = 1'b1;
                    inflight_pc_d = pc_q;
                    if (pc_q == LAST_ADDR) begin
                        stop_d = 1'b1;
                    end else begin
                        pc_d = pc_q + 1'b1;
                    end
                end

                if (inflight_q) begin
                    if (is_halt_word(bus.imem_data)) begin
                        state_d = HALT;
                        stop_d  = 1'b1;
                    end else begin
                        push = 1'b1;
                        if (inflight_pc_q == LAST_ADDR) begin
                            state_d = HALT;
                        end
                    end
                end
            end

            HALT: begin
                // Returns arriving here were issued after the stop point and are dropped.
                if (start && fifo_count == 2'd0) begin
                    state_d = RUN;
                    pc_d    = RESET_ADDR;
                    stop_d  = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= RESET_ADDR;
            stop_q        <= 1'b0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            stop_q        <= stop_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    fetch_fifo #(
        .PC_W (PC_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_inst (bus.imem_data),
        .push_pc   (inflight_pc_q),
        .pop       (pop),
        .count     (fifo_count),
        .head_inst (head_inst),
        .head_pc   (head_pc)
    );

    assign bus.imem_rd_en = issue;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = valid;
    assign bus.inst       = valid ? head_inst : '0;
    assign bus.inst_pc    = valid ? head_pc : '0;
    assign halted         = (state_q == HALT) && (fifo_count == 2'd0);

endmodule
